// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: handshake/data bundle between the EX stage and the
// multiply/divide unit.
//   master modport (EX stage): drives start, op, rs_val, rt_val, flush,
//                              hi_we, lo_we, wdata; observes busy, done, hi, lo
//   slave modport  (MDU):      the reverse
// Parameter WIDTH: operand width; hi/lo are WIDTH bits each.
interface ex_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, flush, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: EX-stage iterative multiply/divide unit with HI/LO registers.
// MULT/MULTU/DIV/DIVU (op 1000/1001/1010/1011) run on magnitudes: WIDTH
// shift-add or restoring shift-subtract iterations, then a sign fix-up cycle.
// busy requests a pipeline stall; done pulses for one cycle when HI/LO are
// written by an operation. MTHI/MTLO writes are accepted only while idle.
// Ports:
//   clk    pipeline clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    ex_muldiv_unit_if.slave (start/op/operands/flush/hi_we/lo_we/wdata in,
//          busy/done/hi/lo out, all outputs registered)
// Optional feature macro: MDU_FAST_MUL_EN -- single-cycle combinational
// multiply (busy for one cycle); divide remains iterative.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    ex_muldiv_unit_if.slave   bus
);
    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    acc;       // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0] opnd;      // multiplicand or divisor magnitude
    logic             is_div;
    logic             res_neg;   // negate product / quotient
    logic             rem_neg;   // remainder takes dividend sign
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    logic             launch;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [DW-1:0]    mul_next;
    logic [WIDTH:0]   div_tmp;
    logic [WIDTH:0]   div_diff;
    logic [DW-1:0]    div_next;
    logic [DW-1:0]    prod_src;
    logic [DW-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand decode, one iteration step of each algorithm, and final sign fix.
    always_comb begin
        launch   = bus.start && (bus.op[3:2] == 2'b10);
        a_neg    = ~bus.op[0] & bus.rs_val[WIDTH-1];
        b_neg    = ~bus.op[0] & bus.rt_val[WIDTH-1];
        a_mag    = a_neg ? (~bus.rs_val + WIDTH'(1)) : bus.rs_val;
        b_mag    = b_neg ? (~bus.rt_val + WIDTH'(1)) : bus.rt_val;

        // Shift-add: add multiplicand to the upper half when multiplier LSB is set, shift right.
        mul_sum  = {1'b0, acc[DW-1:WIDTH]} + {1'b0, (acc[0] ? opnd : WIDTH'(0))};
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Restoring divide: shift in next dividend bit, keep difference if non-negative.
        div_tmp  = {acc[DW-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_tmp - {1'b0, opnd};
        div_next = div_diff[WIDTH] ? {div_tmp[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

`ifdef MDU_FAST_MUL_EN
        prod_src = DW'(opnd) * DW'(acc[WIDTH-1:0]);
`else
        prod_src = acc;
`endif
        prod_fix = res_neg ? (~prod_src + DW'(1)) : prod_src;
        quot_fix = res_neg ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
        rem_fix  = rem_neg ? (~acc[DW-1:WIDTH] + WIDTH'(1)) : acc[DW-1:WIDTH];
    end

    // Control FSM, datapath registers and HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            done_r <= 1'b0;

            // MTHI/MTLO only while idle; FIN never coincides with IDLE so no write conflict.
            if (state == IDLE) begin
                if (bus.hi_we) hi_r <= bus.wdata;
                if (bus.lo_we) lo_r <= bus.wdata;
            end

            if (bus.flush) begin
                state  <= IDLE;
                busy_r <= 1'b0;
                cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (launch) begin
                            is_div  <= bus.op[1];
                            opnd    <= bus.op[1] ? b_mag : a_mag;
                            acc     <= {WIDTH'(0), (bus.op[1] ? a_mag : b_mag)};
                            // Divide by zero keeps the all-ones quotient unsigned-looking.
                            res_neg <= (a_neg ^ b_neg) & ~(bus.op[1] & (bus.rt_val == '0));
                            rem_neg <= a_neg;
                            cnt     <= '0;
                            busy_r  <= 1'b1;
`ifdef MDU_FAST_MUL_EN
                            state   <= bus.op[1] ? RUN : FIN;
`else
                            state   <= RUN;
`endif
                        end
                    end
                    RUN: begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= FIN;
                        end
                    end
                    FIN: begin
                        if (is_div) begin
                            lo_r <= quot_fix;
                            hi_r <= rem_fix;
                        end else begin
                            lo_r <= prod_fix[WIDTH-1:0];
                            hi_r <= prod_fix[DW-1:WIDTH];
                        end
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
